// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcode encodings, the
// multiply/divide sequencer state and the iterative operation select.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_MUL = 6'h02;
  localparam logic [5:0] OP_DIV = 6'h03;
  localparam logic [5:0] OP_MOD = 6'h04;
  localparam logic [5:0] OP_AND = 6'h05;
  localparam logic [5:0] OP_OR  = 6'h06;
  localparam logic [5:0] OP_XOR = 6'h07;
  localparam logic [5:0] OP_NOT = 6'h08;
  localparam logic [5:0] OP_CMP = 6'h09;
  localparam logic [5:0] OP_MOV = 6'h0A;
  localparam logic [5:0] OP_RSR = 6'h0B;
  localparam logic [5:0] OP_RSL = 6'h0C;
  localparam logic [5:0] OP_LSR = 6'h0D;
  localparam logic [5:0] OP_LSL = 6'h0E;
  localparam logic [5:0] OP_TST = 6'h0F;
  localparam logic [5:0] OP_INC = 6'h10;
  localparam logic [5:0] OP_DEC = 6'h11;

  // Sequencer states of the iterative multiply/divide unit
  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } md_state_t;

  // Which iterative operation the multiply/divide unit performs
  typedef enum logic [1:0] {
    MD_MUL,
    MD_DIV,
    MD_MOD
  } md_op_t;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative signed multiply / divide / modulo, one bit per cycle.
// Operands are reduced to magnitudes at start; the sign fix-up is applied
// combinationally on the final iteration so the result is ready on the
// same edge that leaves RUN. The accepting edge loads the operands, the
// following WIDTH edges each retire one bit (counter WIDTH..1).
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_t state, state_next;

  logic [CW-1:0]      count;
  md_op_t             op_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic               neg_res;
  logic               neg_rem;
  logic               div_ovf;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;

  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_signed;
  logic [WIDTH-1:0]   rem_signed;
  logic               mul_ovf;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rst_b) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state: leave RUN on the edge where the last bit is retired
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (count == CW'(1)) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the sequencer state
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_RUN) && (count == CW'(1));
  end

  // One shift-add multiply step and one restoring divide step per cycle
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_step = {mul_sum, prod[WIDTH-1:1]};
    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
    rem_step  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    quo_step  = {quo[WIDTH-2:0], ~div_diff[WIDTH]};
  end

  // Operand load on start, then iterate while running
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      count   <= '0;
      op_q    <= MD_MUL;
      prod    <= '0;
      mcand   <= '0;
      rem     <= '0;
      quo     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div_ovf <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      count   <= CW'(WIDTH);
      op_q    <= op;
      prod    <= {{WIDTH{1'b0}}, a_mag};
      mcand   <= b_mag;
      rem     <= '0;
      quo     <= a_mag;
      neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_rem <= a[WIDTH-1];
      div_ovf <= (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
    end else if (state == ST_RUN) begin
      count <= count - CW'(1);
      prod  <= prod_step;
      rem   <= rem_step;
      quo   <= quo_step;
    end
  end

  // Sign fix-up and overflow detection on the final step's values
  always_comb begin
    prod_signed = neg_res ? -prod_step : prod_step;
    quo_signed  = neg_res ? -quo_step  : quo_step;
    rem_signed  = neg_rem ? -rem_step  : rem_step;
    mul_ovf     = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));
    case (op_q)
      MD_MUL: begin
        result   = prod_signed[WIDTH-1:0];
        overflow = mul_ovf;
      end
      MD_DIV: begin
        result   = quo_signed;
        overflow = div_ovf;
      end
      MD_MOD: begin
        result   = rem_signed;
        overflow = 1'b0;
      end
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU top: single-cycle operations are computed and registered on
// the accepting edge; MUL and DIV/MOD with a non-zero divisor are handed to
// alu_muldiv and registered when it signals completion.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             alu_enable,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] term1,
  input  logic [WIDTH-1:0] term2,
  output logic [WIDTH-1:0] result,
  output logic             fl_zero,
  output logic             fl_negative,
  output logic             fl_carry,
  output logic             fl_overflow,
  output logic             fl_div0,
  output logic             fl_illegal,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             accept;
  logic             is_iter;
  logic             md_start;
  md_op_t           md_op;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic             md_overflow;

  logic [WIDTH-1:0] rhs;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [SHW-1:0]   rot_amt;
  logic [SHW:0]     rot_back;
  logic [WIDTH-1:0] rot_r;
  logic [WIDTH-1:0] rot_l;
  logic [WIDTH:0]   lsr_ext;
  logic [WIDTH:0]   lsl_ext;

  logic [WIDTH-1:0] val;
  logic [WIDTH-1:0] sc_result;
  logic             sc_z;
  logic             sc_n;
  logic             sc_c;
  logic             sc_v;
  logic             sc_div0;
  logic             sc_ill;

  assign accept   = alu_enable && !busy;
  assign is_iter  = (opcode == OP_MUL) ||
                    ((opcode == OP_DIV || opcode == OP_MOD) && term2 != '0);
  assign md_start = accept && is_iter;
  assign md_op    = (opcode == OP_MUL) ? MD_MUL :
                    (opcode == OP_DIV) ? MD_DIV : MD_MOD;

  assign rhs      = (opcode == OP_INC || opcode == OP_DEC) ? ONE : term2;
  assign add_ext  = {1'b0, term1} + {1'b0, rhs};
  assign sub_ext  = {1'b0, term1} - {1'b0, rhs};

  assign rot_amt  = term1[SHW-1:0];
  assign rot_back = (SHW+1)'(WIDTH) - {1'b0, rot_amt};
  assign rot_r    = (term2 >> rot_amt) | (term2 << rot_back);
  assign rot_l    = (term2 << rot_amt) | (term2 >> rot_back);

  // Extra bit below (LSR) / above (LSL) catches the last bit shifted out
  assign lsr_ext  = {term2, 1'b0} >> term1;
  assign lsl_ext  = {1'b0, term2} << term1;

  alu_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (md_start),
    .op       (md_op),
    .a        (term1),
    .b        (term2),
    .busy     (busy),
    .done     (md_done),
    .result   (md_result),
    .overflow (md_overflow)
  );

  // Single-cycle datapath: value for flags, new result and flag set
  always_comb begin
    val       = '0;
    sc_result = result;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    sc_div0   = 1'b0;
    sc_ill    = 1'b0;
    case (opcode)
      OP_ADD, OP_INC: begin
        val       = add_ext[WIDTH-1:0];
        sc_result = val;
        sc_c      = add_ext[WIDTH];
        sc_v      = (term1[WIDTH-1] == rhs[WIDTH-1]) && (val[WIDTH-1] != term1[WIDTH-1]);
      end
      OP_SUB, OP_DEC, OP_CMP: begin
        val = sub_ext[WIDTH-1:0];
        if (opcode != OP_CMP) sc_result = val;
        sc_c = sub_ext[WIDTH];
        sc_v = (term1[WIDTH-1] != rhs[WIDTH-1]) && (val[WIDTH-1] != term1[WIDTH-1]);
      end
      OP_AND, OP_TST: begin
        val = term1 & term2;
        if (opcode == OP_AND) sc_result = val;
      end
      OP_OR: begin
        val       = term1 | term2;
        sc_result = val;
      end
      OP_XOR: begin
        val       = term1 ^ term2;
        sc_result = val;
      end
      OP_NOT: begin
        val       = ~term1;
        sc_result = val;
      end
      OP_MOV: begin
        val       = term2;
        sc_result = val;
      end
      OP_RSR: begin
        val       = rot_r;
        sc_result = val;
        sc_c      = (rot_amt != '0) && rot_r[WIDTH-1];
      end
      OP_RSL: begin
        val       = rot_l;
        sc_result = val;
        sc_c      = (rot_amt != '0) && rot_l[0];
      end
      OP_LSR: begin
        val       = lsr_ext[WIDTH:1];
        sc_result = val;
        sc_c      = lsr_ext[0];
      end
      OP_LSL: begin
        val       = lsl_ext[WIDTH-1:0];
        sc_result = val;
        sc_c      = lsl_ext[WIDTH];
      end
      OP_DIV: begin
        val       = '1;
        sc_result = val;
        sc_div0   = 1'b1;
      end
      OP_MOD: begin
        val       = term1;
        sc_result = val;
        sc_div0   = 1'b1;
      end
      OP_MUL: begin
        val = '0;
      end
      default: begin
        val       = '0;
        sc_result = '0;
        sc_ill    = 1'b1;
      end
    endcase
    sc_z = !sc_ill && (val == '0);
    sc_n = val[WIDTH-1];
  end

  // Result/flag registers and the one-cycle done pulse
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      result      <= '0;
      fl_zero     <= 1'b0;
      fl_negative <= 1'b0;
      fl_carry    <= 1'b0;
      fl_overflow <= 1'b0;
      fl_div0     <= 1'b0;
      fl_illegal  <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (md_done) begin
        result      <= md_result;
        fl_zero     <= (md_result == '0);
        fl_negative <= md_result[WIDTH-1];
        fl_carry    <= 1'b0;
        fl_overflow <= md_overflow;
        fl_div0     <= 1'b0;
        fl_illegal  <= 1'b0;
        done        <= 1'b1;
      end else if (accept && !is_iter) begin
        result      <= sc_result;
        fl_zero     <= sc_z;
        fl_negative <= sc_n;
        fl_carry    <= sc_c;
        fl_overflow <= sc_v;
        fl_div0     <= sc_div0;
        fl_illegal  <= sc_ill;
        done        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter (WIDTH=16) with hand-computed expectations.
// Flags are compared as {zero, negative, carry, overflow, div0, illegal}.
module tb_alu_iter;
  import alu_pkg::*;

  localparam int WIDTH = 16;
  localparam int MAX_CYCLES = 40;

  logic             clk;
  logic             rst_b;
  logic             alu_enable;
  logic [5:0]       opcode;
  logic [WIDTH-1:0] term1;
  logic [WIDTH-1:0] term2;
  logic [WIDTH-1:0] result;
  logic             fl_zero, fl_negative, fl_carry, fl_overflow, fl_div0, fl_illegal;
  logic             busy;
  logic             done;

  int assert_count = 0;
  int fail_count   = 0;
  int cycles       = 0;
  int done_seen    = 0;

  logic [5:0] flags;
  assign flags = {fl_zero, fl_negative, fl_carry, fl_overflow, fl_div0, fl_illegal};

  alu_iter #(
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .alu_enable  (alu_enable),
    .opcode      (opcode),
    .term1       (term1),
    .term2       (term2),
    .result      (result),
    .fl_zero     (fl_zero),
    .fl_negative (fl_negative),
    .fl_carry    (fl_carry),
    .fl_overflow (fl_overflow),
    .fl_div0     (fl_div0),
    .fl_illegal  (fl_illegal),
    .busy        (busy),
    .done        (done)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never returns
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge: present one start, then wait for done
  task automatic applyStimulus(input logic [5:0] op, input logic [15:0] t1,
                               input logic [15:0] t2);
    opcode     = op;
    term1      = t1;
    term2      = t2;
    alu_enable = 1'b1;
    @(negedge clk);
    alu_enable = 1'b0;
    cycles = 1;
    while (!done && cycles < MAX_CYCLES) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    rst_b      = 1'b0;
    alu_enable = 1'b0;
    opcode     = OP_ADD;
    term1      = '0;
    term2      = '0;
    repeat (3) @(negedge clk);

    checkOutput("reset_result", result, 32'h0);
    checkOutput("reset_flags", flags, 6'b000000);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);

    // First start presented together with reset release
    rst_b = 1'b1;
    applyStimulus(OP_ADD, 16'h0005, 16'h000A);
    checkOutput("add_done", done, 1'b1);
    checkOutput("add_latency", cycles, 1);
    checkOutput("add_result", result, 16'h000F);
    checkOutput("add_flags", flags, 6'b000000);
    @(negedge clk);
    checkOutput("add_done_pulse", done, 1'b0);

    applyStimulus(OP_ADD, 16'h7FFF, 16'h0001);
    checkOutput("add_ovf_result", result, 16'h8000);
    checkOutput("add_ovf_flags", flags, 6'b010100);

    // MUL with an ADD request injected while busy
    opcode     = OP_MUL;
    term1      = 16'hFFFF;
    term2      = 16'h000A;
    alu_enable = 1'b1;
    @(negedge clk);
    alu_enable = 1'b0;
    cycles = 1;
    while (!done && cycles < MAX_CYCLES) begin
      if (cycles == 4) begin
        checkOutput("mul_busy", busy, 1'b1);
        opcode     = OP_ADD;
        term1      = 16'h0001;
        term2      = 16'h0001;
        alu_enable = 1'b1;
      end else begin
        alu_enable = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    alu_enable = 1'b0;
    checkOutput("mul_latency", cycles, 17);
    checkOutput("mul_result", result, 16'hFFF6);
    checkOutput("mul_flags", flags, 6'b010000);
    checkOutput("mul_busy_clear", busy, 1'b0);
    @(negedge clk);
    checkOutput("mul_no_queue_done", done, 1'b0);
    checkOutput("mul_no_queue_result", result, 16'hFFF6);

    applyStimulus(OP_MUL, 16'h0100, 16'h0100);
    checkOutput("mul_ovf_result", result, 16'h0000);
    checkOutput("mul_ovf_flags", flags, 6'b100100);

    applyStimulus(OP_DIV, 16'd30, 16'd3);
    checkOutput("div_latency", cycles, 17);
    checkOutput("div_result", result, 16'h000A);
    applyStimulus(OP_MOD, 16'd30, 16'd7);
    checkOutput("mod_result", result, 16'h0002);
    applyStimulus(OP_DIV, 16'hFFF9, 16'h0002);
    checkOutput("div_neg_result", result, 16'hFFFD);
    checkOutput("div_neg_flags", flags, 6'b010000);
    applyStimulus(OP_MOD, 16'hFFF9, 16'h0002);
    checkOutput("mod_neg_result", result, 16'hFFFF);

    applyStimulus(OP_DIV, 16'h0005, 16'h0000);
    checkOutput("div0_latency", cycles, 1);
    checkOutput("div0_result", result, 16'hFFFF);
    checkOutput("div0_flags", flags, 6'b010010);
    applyStimulus(OP_MOD, 16'h1234, 16'h0000);
    checkOutput("mod0_result", result, 16'h1234);
    checkOutput("mod0_flags", flags, 6'b000010);

    applyStimulus(OP_DIV, 16'h8000, 16'hFFFF);
    checkOutput("div_min_result", result, 16'h8000);
    checkOutput("div_min_flags", flags, 6'b010100);
    applyStimulus(OP_MOD, 16'h8000, 16'hFFFF);
    checkOutput("mod_min_result", result, 16'h0000);

    applyStimulus(OP_LSL, 16'd4, 16'h0002);
    checkOutput("lsl_result", result, 16'h0020);
    checkOutput("lsl_flags", flags, 6'b000000);
    applyStimulus(OP_RSR, 16'd4, 16'h0F00);
    checkOutput("rsr_result", result, 16'h00F0);
    checkOutput("rsr_flags", flags, 6'b000000);
    applyStimulus(OP_RSL, 16'd20, 16'h8001);
    checkOutput("rsl_result", result, 16'h0018);
    applyStimulus(OP_LSR, 16'd1, 16'h0001);
    checkOutput("lsr_result", result, 16'h0000);
    checkOutput("lsr_flags", flags, 6'b101000);

    applyStimulus(6'h3F, 16'h1111, 16'h2222);
    checkOutput("illegal_latency", cycles, 1);
    checkOutput("illegal_result", result, 16'h0000);
    checkOutput("illegal_flags", flags, 6'b000001);
    applyStimulus(OP_MOV, 16'h0000, 16'h1234);
    checkOutput("mov_result", result, 16'h1234);
    checkOutput("mov_flags", flags, 6'b000000);
    applyStimulus(OP_CMP, 16'h0020, 16'h0030);
    checkOutput("cmp_result", result, 16'h1234);
    checkOutput("cmp_flags", flags, 6'b011000);

    // Abort a DIV part-way through with reset
    opcode     = OP_DIV;
    term1      = 16'd30;
    term2      = 16'd3;
    alu_enable = 1'b1;
    @(negedge clk);
    alu_enable = 1'b0;
    checkOutput("abort_busy_before", busy, 1'b1);
    repeat (4) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_result", result, 16'h0000);
    checkOutput("abort_done", done, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);

    applyStimulus(OP_SUB, 16'h0010, 16'h000A);
    checkOutput("sub_latency", cycles, 1);
    checkOutput("sub_result", result, 16'h0006);
    checkOutput("sub_flags", flags, 6'b000000);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width (>=8, power of two).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount bits taken from term1.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_b  input  1  reset, synchronous, active-low.
REQ-005 alu_enable  input  1  start request; sampled only while busy=0.
REQ-006 opcode  input  6  operation select, encodings ADD=0x00 SUB=0x01 MUL=0x02 DIV=0x03 MOD=0x04 AND=0x05 OR=0x06 XOR=0x07 NOT=0x08 CMP=0x09 MOV=0x0A RSR=0x0B RSL=0x0C LSR=0x0D LSL=0x0E TST=0x0F INC=0x10 DEC=0x11.
REQ-007 term1, term2  input  WIDTH  operands (two's complement where signed).
REQ-008 result  output  WIDTH  registered result, held until next completion.
REQ-009 fl_zero, fl_negative, fl_carry, fl_overflow  output  1 each  registered flags.
REQ-010 fl_div0, fl_illegal  output  1 each  divide-by-zero / undefined-opcode flags.
REQ-011 busy  output  1  iterative operation in progress.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 Start accepted on edge where alu_enable=1, busy=0; opcode/terms captured at that edge; alu_enable while busy=1 SHALL be ignored (no queueing).
REQ-014 Single-cycle ops (all except MUL/DIV/MOD, plus DIV/MOD with term2=0) SHALL update result/flags and pulse done on the accepting edge; busy stays 0; back-to-back starts every cycle allowed.
REQ-015 MUL/DIV/MOD SHALL set busy on accepting edge, iterate one bit per cycle (shift-add / restoring), update result/flags, pulse done and clear busy on edge WIDTH+1 after acceptance.
REQ-016 States: IDLE -> RUN (counter WIDTH..1) -> IDLE; done asserted on the RUN->IDLE edge.
REQ-017 ADD/SUB/INC/DEC: modulo 2^WIDTH; fl_carry = carry-out (ADD/INC) or borrow (SUB/DEC, unsigned term1<term2); fl_overflow = signed overflow.
REQ-018 CMP SHALL compute term1-term2 flags as SUB; TST SHALL compute term1&term2 flags; both leave result unchanged.
REQ-019 AND/OR/XOR/NOT(~term1)/MOV(term2): fl_carry=fl_overflow=0.
REQ-020 RSR/RSL rotate term2 by term1[SHW-1:0]; LSR/LSL shift term2 logically by term1 (amount>=WIDTH -> 0); fl_carry = last bit shifted out, 0 for amount 0; fl_overflow=0.
REQ-021 MUL signed, result = low WIDTH bits; fl_overflow=1 if signed product not representable in WIDTH; fl_carry=0.
REQ-022 DIV/MOD signed, quotient truncates toward zero, remainder sign of dividend; MIN/-1 -> DIV result MIN, fl_overflow=1, MOD result 0.
REQ-023 term2=0: DIV result all ones, MOD result term1, fl_div0=1, single-cycle.
REQ-024 fl_zero/fl_negative from computed value (incl. CMP/TST); fl_div0, fl_illegal cleared on every other completion.
REQ-025 Undefined opcode: single-cycle, result 0, all arithmetic flags 0, fl_illegal=1, done pulses.

Reset
REQ-026 rst_b=0 at edge SHALL clear result, all flags, busy, done, iteration state; mid-operation abort produces no done.
REQ-027 First start SHALL be accepted on first edge with rst_b=1.

Structure
REQ-028 Opcode constants SHALL live in shared package alu_pkg, reused by ALU and benches.
REQ-029 Iterative multiply/divide SHALL be sub-module alu_muldiv (WIDTH param, start/busy/done handshake, sign fix-up inside).

Verification (WIDTH=16)
REQ-030 ADD 0x0005+0x000A -> result 0x000F, done 1 cycle, flags 0; ADD 0x7FFF+0x0001 -> 0x8000, fl_overflow=1, fl_negative=1.
REQ-031 MUL 0xFFFF*0x000A -> 0xFFF6 on edge 17, busy 16+ cycles, ADD pulsed during busy ignored.
REQ-032 DIV 30/3 -> 10; MOD 30/7 -> 2; DIV -7/2 -> 0xFFFD; MOD -7/2 -> 0xFFFF; DIV 5/0 -> 0xFFFF, fl_div0=1, done 1 cycle.
REQ-033 LSL 0x0002 by 4 -> 0x0020; RSR 0x0F00 by 4 -> 0x00F0; RSL 0x8001 by 20 -> 0x0018; LSR 0x0001 by 1 -> 0, fl_carry=1, fl_zero=1.
REQ-034 rst_b=0 on cycle 5 of DIV -> busy=0, result 0, no done; following SUB 0x0010-0x000A -> 0x0006.
REQ-035 Opcode 0x3F -> fl_illegal=1, result 0, done pulse; CMP 0x0020 vs 0x0030 -> fl_carry=1, fl_negative=1, result unchanged.
